imem_loader: RTL and testbench

Writer side of the instruction-memory debug write port. Receives a byte stream from a host/debug link and packs it into 32-bit words, first byte as MSB. Writes each word into imem through the ram_ena/ram_wena/ram_indata port. Holds the CPU stalled (cpu_hold drives pc_ena low) for the whole load, then releases it.

---
 rtl/imem_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Packs a host byte stream (first byte = MSB) into 32-bit words and writes them into imem,
// holding the CPU for the whole load. Optional trailing XOR checksum: `define LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_ram_ena,
    output logic              o_ram_wena,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [31:0]       o_ram_indata,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_CKSUM} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_word_idx;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_word;
    logic              r_in_ready;
    logic              r_ram_ena;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_ram_indata;
    logic              r_busy;
    logic              r_done;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
    logic              r_err;
`endif

    logic w_last_word;
    assign w_last_word = ((LEN_W+1)'(r_word_idx) + (LEN_W+1)'(1)) == (LEN_W+1)'(r_len);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_len        <= '0;
            r_word_idx   <= '0;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_in_ready   <= 1'b0;
            r_ram_ena    <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_indata <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor        <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_ram_ena <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_base     <= i_base_addr;
                    r_len      <= i_len;
                    r_word_idx <= '0;
                    r_byte_cnt <= '0;
                    r_word     <= '0;
                    r_busy     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    r_xor      <= '0;
                    r_err      <= 1'b0;
                    if (i_len == '0) begin
                        r_state    <= S_CKSUM;
                        r_in_ready <= 1'b1;
                    end
`else
                    if (i_len == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
`endif
                    else begin
                        r_state    <= S_RECV;
                        r_in_ready <= 1'b1;
                    end
                end
                S_RECV: if (i_in_valid) begin
                    r_word     <= {r_word[15:0], i_in_data};
                    r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    r_xor      <= r_xor ^ i_in_data;
`endif
                    // Output word register is loaded on the 4th accept so WRITE presents it directly.
                    if (r_byte_cnt == 2'd3) begin
                        r_state      <= S_WRITE;
                        r_in_ready   <= 1'b0;
                        r_ram_ena    <= 1'b1;
                        r_ram_addr   <= r_base + ADDR_W'(r_word_idx);
                        r_ram_indata <= {r_word, i_in_data};
                    end
                end
                S_WRITE: begin
                    r_word_idx <= r_word_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    if (w_last_word) begin
                        r_state    <= S_CKSUM;
                        r_in_ready <= 1'b1;
                    end
`else
                    if (w_last_word) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
`endif
                    else begin
                        r_state    <= S_RECV;
                        r_in_ready <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CKSUM: if (i_in_valid) begin
                    r_err      <= (i_in_data != r_xor);
                    r_in_ready <= 1'b0;
                    r_state    <= S_DONE;
                    r_done     <= 1'b1;
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_ram_ena    = r_ram_ena;
    assign o_ram_wena   = r_ram_ena;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_indata = r_ram_indata;
    assign o_cpu_hold   = r_busy;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
`ifdef LOADER_CHECKSUM_EN
    assign o_err        = r_err;
`else
    assign o_err        = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: word packing, stalls, len=0, address wrap, mid-load reset
// and (when LOADER_CHECKSUM_EN is defined) the trailing checksum byte.
`timescale 1ns/1ps
module tb_imem_loader;
`ifdef LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base = '0;
    logic [7:0]  len = '0;
    logic [7:0]  din = '0;
    logic        vld = 1'b0;
    logic        rdy, ena, wena, hold, busy, done, err;
    logic [7:0]  addr;
    logic [31:0] wdata;

    imem_loader #(.ADDR_W(8), .LEN_W(8)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_base_addr(base), .i_len(len),
        .i_in_data(din), .i_in_valid(vld), .o_in_ready(rdy), .o_ram_ena(ena),
        .o_ram_wena(wena), .o_ram_addr(addr), .o_ram_indata(wdata), .o_cpu_hold(hold),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/done/hold monitor, sampled on the falling edge.
    int          nwr = 0, ndone = 0, nhold = 0, dcyc = 0;
    logic        derr = 1'b0;
    logic [7:0]  wa [64];
    logic [31:0] wd [64];
    int          wc [64];
    always @(negedge clk) begin
        if (wena) begin
            if (nwr < 64) begin
                wa[nwr] = addr;
                wd[nwr] = wdata;
                wc[nwr] = cyc;
            end
            nwr++;
        end
        if (done) begin
            ndone++;
            dcyc = cyc;
            derr = err;
        end
        if (hold) nhold++;
    end

    int tests = 0, fails = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [7:0] bytes [16];
    int c0, w0, d0, h0;

    task automatic set_word(input int i, input logic [31:0] w);
        for (int k = 0; k < 4; k++) bytes[i*4+k] = w[31-8*k -: 8];
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        din = b;
        vld = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!rdy) chk("rdy_timeout", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [7:0] b, input logic [7:0] n);
        @(negedge clk);
        start = 1'b1;
        base  = b;
        len   = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic run_load(input logic [7:0] b, input logic [7:0] n, input int stall_at,
                            input int stall_n, input logic ck_bad);
        logic [7:0] x;
        int t;
        w0 = nwr; d0 = ndone; h0 = nhold;
        x = '0;
        start_load(b, n);
        for (int i = 0; i < 4 * int'(n); i++) begin
            if (i == stall_at) begin
                vld = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    chk("stall_rdy", 32'(rdy), 32'd1);
                    @(posedge clk);
                    #1;
                end
            end
            send_byte(bytes[i]);
            x = x ^ bytes[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x ^ {7'd0, ck_bad});
`endif
        vld = 1'b0;
        t = 0;
        while (ndone == d0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("done_count", 32'(ndone - d0), 32'd1);
        chk("idle_after", {29'd0, hold, busy, rdy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {25'd0, rdy, ena, wena, hold, busy, done, err}, 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_data", wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic two-word load
        set_word(0, 32'h12345678);
        set_word(1, 32'hAABBCCDD);
        run_load(8'h10, 8'd2, -1, 0, 1'b0);
        chk("t1_nwr", 32'(nwr - w0), 32'd2);
        chk("t1_a0", 32'(wa[w0]), 32'h10);
        chk("t1_d0", wd[w0], 32'h12345678);
        chk("t1_lat0", 32'(wc[w0] - c0), 32'd4);
        chk("t1_a1", 32'(wa[w0+1]), 32'h11);
        chk("t1_d1", wd[w0+1], 32'hAABBCCDD);
        chk("t1_lat1", 32'(wc[w0+1] - c0), 32'd9);
        chk("t1_done", 32'(dcyc - wc[w0+1]), 32'(1 + CK));
        chk("t1_hold", 32'(nhold - h0), 32'(11 + CK));

        // Three-cycle stall after byte 2
        run_load(8'h10, 8'd2, 2, 3, 1'b0);
        chk("t2_d0", wd[w0], 32'h12345678);
        chk("t2_lat0", 32'(wc[w0] - c0), 32'd7);
        chk("t2_lat1", 32'(wc[w0+1] - c0), 32'd12);
        chk("t2_d1", wd[w0+1], 32'hAABBCCDD);

        // Zero-length load
        run_load(8'h20, 8'd0, -1, 0, 1'b0);
        chk("t3_nwr", 32'(nwr - w0), 32'd0);
        chk("t3_done", 32'(dcyc - c0), 32'(CK));
        chk("t3_hold", 32'(nhold - h0), 32'(1 + CK));

        // Address wrap
        set_word(0, 32'hCAFEF00D);
        set_word(1, 32'h0BADBEEF);
        run_load(8'hFF, 8'd2, -1, 0, 1'b0);
        chk("t4_a0", 32'(wa[w0]), 32'hFF);
        chk("t4_a1", 32'(wa[w0+1]), 32'h00);
        chk("t4_d1", wd[w0+1], 32'h0BADBEEF);

        // Reset after 6 bytes of a 3-word load
        set_word(0, 32'h01234567);
        set_word(1, 32'h89ABCDEF);
        w0 = nwr; d0 = ndone;
        start_load(8'h30, 8'd3);
        for (int i = 0; i < 6; i++) send_byte(bytes[i]);
        vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_async", {28'd0, hold, busy, rdy, ena}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_nodone", 32'(ndone - d0), 32'd0);
        chk("t5_nwr", 32'(nwr - w0), 32'd1);
        set_word(0, 32'h11223344);
        run_load(8'h40, 8'd1, -1, 0, 1'b0);
        chk("t5_a", 32'(wa[w0]), 32'h40);
        chk("t5_d", wd[w0], 32'h11223344);

`ifdef LOADER_CHECKSUM_EN
        // Checksum good then bad
        set_word(0, 32'h01020408);
        run_load(8'h50, 8'd1, -1, 0, 1'b0);
        chk("t6_err_ok", 32'(derr), 32'd0);
        run_load(8'h50, 8'd1, -1, 0, 1'b1);
        chk("t6_err_bad", 32'(derr), 32'd1);
        chk("t6_d", wd[w0], 32'h01020408);
        chk("t6_err_hold", 32'(err), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
